// File: rtl/prom_sync.sv
// prom_sync: loadable synchronous PROM.
// After reset the block sits in LOAD and accepts DEPTH words over a valid/ready
// stream, written to consecutive addresses from 0 while a running checksum is
// kept. After the last word it enters RUN, where reads are accepted once per
// cycle and returned RD_LAT cycles later. prog_en in RUN re-enters LOAD.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous active-high reset
//   addr       - read address, sampled with ce_n
//   ce_n       - active-low read enable
//   dout       - registered read data (0 when no read completes)
//   rd_valid   - dout holds data for a read issued RD_LAT cycles earlier
//   prog_en    - request to (re)enter program mode (only acted on in RUN)
//   prog_data  - program word
//   prog_valid - prog_data valid
//   prog_ready - block accepts a program word this cycle (LOAD)
//   prog_done  - all words loaded, block in RUN
//   checksum   - modulo 2**DATA_W sum of words loaded since last LOAD entry
module prom_sync #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ce_n,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  input  logic              prog_en,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {StLoad, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lptr_q, lptr_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              xfer;
  logic              rd_issue;

  logic [DATA_W-1:0] mem [Depth];

  // Read pipeline, stage RD_LAT-1 drives the outputs.
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_comb begin
    state_d    = state_q;
    lptr_d     = lptr_q;
    csum_d     = csum_q;
    prog_ready = (state_q == StLoad);
    prog_done  = (state_q == StRun);
    // Reset blocks the memory write too, so a word on the reset cycle is dropped.
    xfer       = prog_ready & prog_valid & ~reset;
    rd_issue   = prog_done & ~ce_n;
    unique case (state_q)
      StLoad: begin
        if (prog_valid) begin
          lptr_d = lptr_q + 1'b1;
          csum_d = csum_q + prog_data;
          if (&lptr_q) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (prog_en) begin
          state_d = StLoad;
          lptr_d  = '0;
          csum_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      lptr_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      lptr_q  <= lptr_d;
      csum_q  <= csum_d;
    end
  end

  // Memory is not reset; contents survive reset and RUN->LOAD until rewritten.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[lptr_q] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_issue;
      dat_q[0] <= rd_issue ? mem[addr] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign dout     = dat_q[RD_LAT-1];
  assign rd_valid = vld_q[RD_LAT-1];
  assign checksum = csum_q;

endmodule
